// File: rtl/uart_matrix_tx_framer.sv
// uart_matrix_tx_framer: streams an N x N byte matrix to a byte UART as
// a frame of HEADER, N*N payload bytes (row-major, address 0 first), FOOTER.
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   start       - one-cycle frame request, honoured only in IDLE
//   rd_addr     - matrix memory read address
//   rd_en       - read strobe; rd_data valid one cycle later
//   rd_data     - matrix byte from memory
//   tx_data     - byte for the UART transmitter
//   tx_start    - one-cycle launch pulse for tx_data
//   tx_busy     - UART transmitter busy
//   busy        - frame in progress
//   done        - one-cycle pulse once the FOOTER has left the UART
//   bytes_sent  - payload bytes launched in the current/last frame
//
// Build option: define FRAMER_CHECKSUM_EN to append an 8-bit XOR of the
// payload between the last payload byte and the FOOTER.

module uart_matrix_tx_framer #(
  parameter int          N      = 16,
  parameter logic [7:0]  HEADER = 8'hAA,
  parameter logic [7:0]  FOOTER = 8'h55,
  parameter int          ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [7:0]        rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   bytes_sent
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N * N - 1);

  typedef enum logic [3:0] {
    IDLE,
    SEND_HDR,
    FETCH,
    LATCH,
    SEND_BYTE,
    WAIT_HI,
    WAIT_LO,
    SEND_FTR,
`ifdef FRAMER_CHECKSUM_EN
    SEND_CSUM,
`endif
    FINISH
  } state_t;

  // Which kind of byte is currently on its way out; decides where
  // WAIT_LO goes once the UART is free again.
  typedef enum logic [1:0] {
    K_HDR,
    K_PAY,
    K_CSUM,
    K_FTR
  } kind_t;

  state_t state;
  kind_t  kind;

  // Set after the first WAIT_HI cycle; a second cycle without tx_busy
  // means the UART finished (or never signalled) and the byte is done.
  logic   hi_seen;

`ifdef FRAMER_CHECKSUM_EN
  logic [7:0] csum;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      kind       <= K_HDR;
      hi_seen    <= 1'b0;
      rd_addr    <= '0;
      rd_en      <= 1'b0;
      tx_data    <= 8'h00;
      tx_start   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bytes_sent <= '0;
`ifdef FRAMER_CHECKSUM_EN
      csum       <= 8'h00;
`endif
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      rd_en    <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            bytes_sent <= '0;
            rd_addr    <= '0;
`ifdef FRAMER_CHECKSUM_EN
            csum       <= 8'h00;
`endif
            state      <= SEND_HDR;
          end
        end

        SEND_HDR: begin
          if (!tx_busy) begin
            tx_data  <= HEADER;
            tx_start <= 1'b1;
            kind     <= K_HDR;
            hi_seen  <= 1'b0;
            state    <= WAIT_HI;
          end
        end

        WAIT_HI: begin
          if (tx_busy || hi_seen) begin
            state <= WAIT_LO;
          end else begin
            hi_seen <= 1'b1;
          end
        end

        WAIT_LO: begin
          if (!tx_busy) begin
            unique case (kind)
              K_HDR: begin
                rd_en <= 1'b1;
                state <= FETCH;
              end
              K_PAY: begin
                if (rd_addr != LAST) begin
                  rd_addr <= rd_addr + 1'b1;
                  rd_en   <= 1'b1;
                  state   <= FETCH;
                end else begin
`ifdef FRAMER_CHECKSUM_EN
                  state <= SEND_CSUM;
`else
                  state <= SEND_FTR;
`endif
                end
              end
              K_CSUM: state <= SEND_FTR;
              K_FTR:  state <= FINISH;
            endcase
          end
        end

        // rd_en was raised on entry, so memory samples rd_addr this cycle
        FETCH: begin
          state <= LATCH;
        end

        LATCH: begin
          tx_data <= rd_data;
`ifdef FRAMER_CHECKSUM_EN
          csum    <= csum ^ rd_data;
`endif
          state   <= SEND_BYTE;
        end

        SEND_BYTE: begin
          if (!tx_busy) begin
            tx_start   <= 1'b1;
            bytes_sent <= bytes_sent + 1'b1;
            kind       <= K_PAY;
            hi_seen    <= 1'b0;
            state      <= WAIT_HI;
          end
        end

`ifdef FRAMER_CHECKSUM_EN
        SEND_CSUM: begin
          if (!tx_busy) begin
            tx_data  <= csum;
            tx_start <= 1'b1;
            kind     <= K_CSUM;
            hi_seen  <= 1'b0;
            state    <= WAIT_HI;
          end
        end
`endif

        SEND_FTR: begin
          if (!tx_busy) begin
            tx_data  <= FOOTER;
            tx_start <= 1'b1;
            kind     <= K_FTR;
            hi_seen  <= 1'b0;
            state    <= WAIT_HI;
          end
        end

        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_matrix_tx_framer.sv
// Bench for uart_matrix_tx_framer with N=4: random and fixed matrices,
// UART model with normal, held-busy and zero-latency behaviour.

module tb_uart_matrix_tx_framer;

  localparam int N  = 4;
  localparam int NN = N * N;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [7:0]    rd_data = 8'h00;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy;
  logic          busy;
  logic          done;
  logic [AW:0]   bytes_sent;

  uart_matrix_tx_framer #(
    .N(N), .HEADER(8'hAA), .FOOTER(8'h55), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .busy(busy), .done(done), .bytes_sent(bytes_sent)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:NN-1];
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr[3:0]];
  end

  // UART model and protocol monitor
  int         busy_cnt = 0;
  logic       zero_lat = 1'b0;
  logic       hold_busy = 1'b0;
  logic       prev_start = 1'b0;
  logic [7:0] last_byte = 8'h00;
  logic [7:0] wire_q [$];
  int         done_cnt = 0;
  int         viol = 0;

  assign tx_busy = (busy_cnt != 0) | hold_busy;

  always @(posedge clk) begin
    if (reset) begin
      busy_cnt   <= 0;
      prev_start <= 1'b0;
    end else begin
      prev_start <= tx_start;
      if (tx_start) begin
        wire_q.push_back(tx_data);
        last_byte <= tx_data;
      end
      if (done) done_cnt <= done_cnt + 1;
      viol <= viol
            + int'(tx_start && tx_busy)
            + int'(tx_start && prev_start)
            + int'(busy_cnt != 0 && tx_data !== last_byte)
            + int'(rd_en && rd_addr > AW'(NN - 1));
      if (tx_start && !zero_lat) busy_cnt <= 10;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
  end

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q [$];

  // Reference frame straight from the framing rules
  function automatic void build_exp();
    logic [7:0] x;
    x = 8'h00;
    exp_q.delete();
    exp_q.push_back(8'hAA);
    for (int i = 0; i < NN; i++) begin
      exp_q.push_back(mem[i]);
      x ^= mem[i];
    end
`ifdef FRAMER_CHECKSUM_EN
    exp_q.push_back(x);
`endif
    exp_q.push_back(8'h55);
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (done_cnt > d0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    total += 7;
    if (rd_addr !== '0) begin bad++; $display("FAIL reset rd_addr got=%0h want=0", rd_addr); end
    if (rd_en !== 1'b0) begin bad++; $display("FAIL reset rd_en got=%b want=0", rd_en); end
    if (tx_data !== 8'h00) begin bad++; $display("FAIL reset tx_data got=%0h want=0", tx_data); end
    if (tx_start !== 1'b0) begin bad++; $display("FAIL reset tx_start got=%b want=0", tx_start); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b want=0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL reset done got=%b want=0", done); end
    if (bytes_sent !== '0) begin bad++; $display("FAIL reset bytes_sent got=%0d want=0", bytes_sent); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // mode: 0 counting pattern, 1 random, 2 all 0x5A
  task automatic test_frame(input string name, input int mode);
    int base, d0, v0, n;
    bit ok;
    for (int i = 0; i < NN; i++)
      mem[i] = (mode == 0) ? 8'(i) : (mode == 1) ? 8'($urandom_range(0, 255)) : 8'h5A;
    build_exp();
    base = wire_q.size();
    d0 = done_cnt;
    v0 = viol;
    pulse_start();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_after_start got=%b want=1", name, busy); end
    wait_done(d0, 3000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL %s done_timeout got=0 want=1", name); end
    total += 2;
    if (bytes_sent !== (AW+1)'(NN)) begin bad++; $display("FAIL %s bytes_sent got=%0d want=%0d", name, bytes_sent, NN); end
    if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_at_done got=%b want=0", name, busy); end
    repeat (30) @(negedge clk);
    n = wire_q.size() - base;
    total++;
    if (n != exp_q.size()) begin bad++; $display("FAIL %s frame_len got=%0d want=%0d", name, n, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      total++;
      if (wire_q[base+i] !== exp_q[i]) begin
        bad++; $display("FAIL %s byte%0d got=%0h want=%0h", name, i, wire_q[base+i], exp_q[i]);
      end
    end
    total += 2;
    if (done_cnt - d0 != 1) begin bad++; $display("FAIL %s done_pulses got=%0d want=1", name, done_cnt - d0); end
    if (viol != v0) begin bad++; $display("FAIL %s protocol got=%0d want=0", name, viol - v0); end
  endtask

  task automatic test_busy_hold();
    int base, d0, v0, n;
    bit ok;
    for (int i = 0; i < NN; i++) mem[i] = 8'($urandom_range(0, 255));
    build_exp();
    base = wire_q.size();
    d0 = done_cnt;
    v0 = viol;
    hold_busy = 1'b1;
    pulse_start();
    repeat (50) @(negedge clk);
    total++;
    if (wire_q.size() != base) begin bad++; $display("FAIL hold no_start got=%0d want=%0d", wire_q.size() - base, 0); end
    hold_busy = 1'b0;
    wait_done(d0, 3000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL hold done_timeout got=0 want=1"); end
    repeat (5) @(negedge clk);
    n = wire_q.size() - base;
    total += 3;
    if (n != exp_q.size()) begin bad++; $display("FAIL hold frame_len got=%0d want=%0d", n, exp_q.size()); end
    if (n > 0 && wire_q[base] !== 8'hAA) begin bad++; $display("FAIL hold header got=%0h want=aa", wire_q[base]); end
    if (viol != v0) begin bad++; $display("FAIL hold protocol got=%0d want=0", viol - v0); end
  endtask

  task automatic test_restart_ignored();
    int base, d0, n, guard;
    bit ok;
    for (int i = 0; i < NN; i++) mem[i] = 8'($urandom_range(0, 255));
    build_exp();
    base = wire_q.size();
    d0 = done_cnt;
    pulse_start();
    guard = 0;
    while (wire_q.size() - base < 6 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    pulse_start();
    wait_done(d0, 3000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL restart done_timeout got=0 want=1"); end
    repeat (200) @(negedge clk);
    n = wire_q.size() - base;
    total += 2;
    if (n != exp_q.size()) begin bad++; $display("FAIL restart frame_len got=%0d want=%0d", n, exp_q.size()); end
    if (done_cnt - d0 != 1) begin bad++; $display("FAIL restart done_pulses got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_reset_abort();
    int base, cnt, guard;
    for (int i = 0; i < NN; i++) mem[i] = 8'($urandom_range(0, 255));
    base = wire_q.size();
    pulse_start();
    cnt = 0;
    guard = 0;
    while (cnt < 4 && guard < 2000) begin
      @(negedge clk);
      if (tx_start) cnt++;
      guard++;
    end
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    total += 4;
    if (tx_start !== 1'b0) begin bad++; $display("FAIL abort tx_start got=%b want=0", tx_start); end
    if (busy !== 1'b0) begin bad++; $display("FAIL abort busy got=%b want=0", busy); end
    if (bytes_sent !== '0) begin bad++; $display("FAIL abort bytes_sent got=%0d want=0", bytes_sent); end
    if (rd_addr !== '0) begin bad++; $display("FAIL abort rd_addr got=%0d want=0", rd_addr); end
    reset = 1'b0;
    repeat (40) @(negedge clk);
    total++;
    if (wire_q.size() - base != 4) begin bad++; $display("FAIL abort no_footer got=%0d want=4", wire_q.size() - base); end
    test_frame("after_abort", 1);
  endtask

  initial begin
    test_reset();
    test_frame("count", 0);
    test_frame("rand_a", 1);
    test_frame("rand_b", 1);
    test_frame("const5a", 2);
    test_busy_hold();
    test_restart_ignored();
    test_reset_abort();
    zero_lat = 1'b1;
    test_frame("zero_lat", 1);
    zero_lat = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
